// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared constants, the state encoding and the source-page remap helper for
// the sprite-attribute (OAM) DMA engine.
//   OAM_BYTES    : bytes copied per transfer
//   OAM_BASE     : CPU-visible base address of OAM
//   DMA_REG_ADDR : CPU address of the DMA start register
//   dma_state_e  : IDLE / XFER
//   remap_page() : folds echo-RAM pages 0xE0-0xFF down onto 0xC0-0xDF
// -----------------------------------------------------------------------------
package oam_dma_pkg;

   localparam int          OAM_BYTES    = 160;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [7:0]  OAM_LAST_IDX = 8'(OAM_BYTES - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } dma_state_e;

   // Pages 0xE0-0xFF alias work RAM (echo region); clearing bit 5 maps them
   // onto 0xC0-0xDF so the copy reads real RAM instead of unmapped space.
   function automatic logic [7:0] remap_page(input logic [7:0] value);
      logic [7:0] page;
      page = value;
      if (value[7:5] == 3'b111) begin
         page[5] = 1'b0;
      end
      return page;
   endfunction

endpackage

// File: rtl/dma_phase_ctr.sv
// -----------------------------------------------------------------------------
// dma_phase_ctr
// Byte-index / sub-byte phase counter pair for the OAM DMA engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force phase and idx to 0 (has priority over enable)
//   enable     : advance phase; idx steps when phase wraps
//   phase      : 0 .. CYCLES_PER_BYTE-1
//   idx        : 0 .. OAM_BYTES-1 (wraps back to 0 after the last byte)
//   last       : final phase of the final byte
// -----------------------------------------------------------------------------
module dma_phase_ctr
   import oam_dma_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int PHASE_W         = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               enable,
   output logic [PHASE_W-1:0] phase,
   output logic [7:0]         idx,
   output logic               last
);

   localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(CYCLES_PER_BYTE - 1);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [7:0]         idx_q, idx_d;

   always_comb begin
      phase_d = phase_q;
      idx_d   = idx_q;
      if (clear) begin
         phase_d = '0;
         idx_d   = '0;
      end else if (enable) begin
         if (phase_q == PH_LAST) begin
            phase_d = '0;
            // Wrap idx at the end so it can never present an address past 159.
            idx_d   = (idx_q == OAM_LAST_IDX) ? 8'd0 : idx_q + 8'd1;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         idx_q   <= '0;
      end else begin
         phase_q <= phase_d;
         idx_q   <= idx_d;
      end
   end

   assign phase = phase_q;
   assign idx   = idx_q;
   assign last  = (idx_q == OAM_LAST_IDX) && (phase_q == PH_LAST);

endmodule

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite-attribute DMA engine. A write to the DMA register copies 160 bytes
// from source page {value, 8'h00} into OAM index 0..159, one byte every
// CYCLES_PER_BYTE clocks. Acts as an alternate bus master in front of the
// source BRAMs and the OAM BRAM; busy tells the arbiter to lock the CPU to HRAM.
//
// Parameters: CYCLES_PER_BYTE (>= 2), RD_LATENCY (< CYCLES_PER_BYTE)
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   reg_we, reg_wdata   : decoded CPU write to the DMA register
//   reg_rdata           : CPU readback of the DMA register
//   src_addr, src_re    : source read request
//   src_rdata           : source data, RD_LATENCY cycles after src_re
//   dst_addr, dst_wdata,
//   dst_we              : OAM write port (dst_wdata = src_rdata)
//   busy                : transfer in progress
//   done                : one-cycle pulse after a completed transfer
//
// Build option: OAM_DMA_READBACK_EN - reg_rdata returns the last raw value
// written; otherwise it reads as open bus (0xFF).
// -----------------------------------------------------------------------------
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int RD_LATENCY      = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reg_we,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic [15:0] src_addr,
   output logic        src_re,
   input  logic [7:0]  src_rdata,
   output logic [7:0]  dst_addr,
   output logic [7:0]  dst_wdata,
   output logic        dst_we,
   output logic        busy,
   output logic        done
);

   localparam int                 PHASE_W = $clog2(CYCLES_PER_BYTE);
   localparam logic [PHASE_W-1:0] PH_WR   = PHASE_W'(RD_LATENCY);

   dma_state_e         state_q, state_d;
   logic [7:0]         page_q, page_d;
   logic               done_q, done_d;

   logic [PHASE_W-1:0] phase;
   logic [7:0]         idx;
   logic               ctr_last;
   logic               ctr_en;

   dma_phase_ctr #(
      .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
      .PHASE_W         (PHASE_W)
   ) u_phase_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (reg_we),
      .enable (ctr_en),
      .phase  (phase),
      .idx    (idx),
      .last   (ctr_last)
   );

   assign ctr_en = (state_q == XFER);

   // A register write always (re)starts the copy, even mid-transfer; the
   // aborted transfer therefore never reaches its last cycle and never
   // produces done.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      done_d  = 1'b0;
      if (reg_we) begin
         page_d  = remap_page(reg_wdata);
         state_d = XFER;
      end else if ((state_q == XFER) && ctr_last) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         page_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         done_q  <= done_d;
      end
   end

   // Strobes are decoded from registered state only, so an asynchronous reset
   // drops them (and any in-flight OAM write) immediately. RD_LATENCY is
   // nonzero, so the read and write phases can never coincide.
   assign busy      = (state_q == XFER);
   assign src_re    = busy && (phase == '0);
   assign dst_we    = busy && (phase == PH_WR);
   assign src_addr  = {page_q, idx};
   assign dst_addr  = idx;
   assign dst_wdata = src_rdata;
   assign done      = done_q;

`ifdef OAM_DMA_READBACK_EN
   logic [7:0] rdback_q, rdback_d;

   always_comb begin
      rdback_d = rdback_q;
      if (reg_we) begin
         rdback_d = reg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdback_q <= 8'h00;
      end else begin
         rdback_q <= rdback_d;
      end
   end

   assign reg_rdata = rdback_q;
`else
   assign reg_rdata = 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Directed bench for oam_dma: instance A uses the default timing (4 cycles per
// byte), instance B runs at 2 cycles per byte. Each instance has its own model
// of a 1-cycle-latency source memory and a model of the OAM array.
// -----------------------------------------------------------------------------
module tb_oam_dma;

   logic        clk;
   logic        rst_n;

   logic        reg_we_a, reg_we_b;
   logic [7:0]  reg_wdata_a, reg_wdata_b;
   logic [7:0]  reg_rdata_a, reg_rdata_b;
   logic [15:0] src_addr_a, src_addr_b;
   logic        src_re_a, src_re_b;
   logic [7:0]  src_rdata_a, src_rdata_b;
   logic [7:0]  dst_addr_a, dst_addr_b;
   logic [7:0]  dst_wdata_a, dst_wdata_b;
   logic        dst_we_a, dst_we_b;
   logic        busy_a, busy_b;
   logic        done_a, done_b;

   oam_dma u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .reg_we    (reg_we_a),
      .reg_wdata (reg_wdata_a),
      .reg_rdata (reg_rdata_a),
      .src_addr  (src_addr_a),
      .src_re    (src_re_a),
      .src_rdata (src_rdata_a),
      .dst_addr  (dst_addr_a),
      .dst_wdata (dst_wdata_a),
      .dst_we    (dst_we_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   oam_dma #(
      .CYCLES_PER_BYTE (2),
      .RD_LATENCY      (1)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .reg_we    (reg_we_b),
      .reg_wdata (reg_wdata_b),
      .reg_rdata (reg_rdata_b),
      .src_addr  (src_addr_b),
      .src_re    (src_re_b),
      .src_rdata (src_rdata_b),
      .dst_addr  (dst_addr_b),
      .dst_wdata (dst_wdata_b),
      .dst_we    (dst_we_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory and OAM models ----------------
   logic [7:0]  mem [0:65535];
   logic [7:0]  oam_a [0:159];
   logic [7:0]  oam_b [0:159];
   int          wr_cnt_a [0:159];

   logic        pend_a, pend_b;
   logic [15:0] pend_addr_a, pend_addr_b;

   // Monotonic monitor counters; the stimulus only takes snapshots of them.
   int busy_cyc_a, busy_cyc_b, done_cnt_a, done_cnt_b;
   int overlap_a, bad_addr_a, bad_addr_b, done_busy_a, alt_err_b;
   logic [15:0] last_src_a;

   initial begin
      pend_a = 1'b0; pend_b = 1'b0;
      pend_addr_a = '0; pend_addr_b = '0;
      src_rdata_a = '0; src_rdata_b = '0;
      busy_cyc_a = 0; busy_cyc_b = 0; done_cnt_a = 0; done_cnt_b = 0;
      overlap_a = 0; bad_addr_a = 0; bad_addr_b = 0; done_busy_a = 0;
      alt_err_b = 0; last_src_a = '0;
      for (int i = 0; i < 160; i++) begin
         oam_a[i] = 8'h00; oam_b[i] = 8'h00; wr_cnt_a[i] = 0;
      end
   end

   // Outputs are sampled on the falling edge; read data is returned on the
   // next rising edge (1-cycle source latency).
   always @(negedge clk) begin
      pend_a <= src_re_a;
      pend_addr_a <= src_addr_a;
      if (src_re_a) last_src_a <= src_addr_a;
      if (dst_we_a) begin
         if (dst_addr_a > 8'd159) bad_addr_a <= bad_addr_a + 1;
         else begin
            oam_a[dst_addr_a]    <= dst_wdata_a;
            wr_cnt_a[dst_addr_a] <= wr_cnt_a[dst_addr_a] + 1;
         end
      end
      if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (src_re_a && dst_we_a) overlap_a <= overlap_a + 1;
      if (done_a && busy_a) done_busy_a <= done_busy_a + 1;
   end

   always @(negedge clk) begin
      pend_b <= src_re_b;
      pend_addr_b <= src_addr_b;
      if (dst_we_b) begin
         if (dst_addr_b > 8'd159) bad_addr_b <= bad_addr_b + 1;
         else oam_b[dst_addr_b] <= dst_wdata_b;
      end
      if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      // At 2 cycles/byte every busy cycle is exactly one read or one write.
      if (busy_b && (src_re_b == dst_we_b)) alt_err_b <= alt_err_b + 1;
   end

   always @(posedge clk) begin
      if (pend_a) src_rdata_a <= mem[pend_addr_a];
      if (pend_b) src_rdata_b <= mem[pend_addr_b];
   end

   // ---------------- checking ----------------
   int tests_run;
   int tests_failed;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_reg_a(input logic [7:0] v);
      @(negedge clk);
      reg_we_a = 1'b1; reg_wdata_a = v;
      @(negedge clk);
      reg_we_a = 1'b0;
   endtask

   task automatic write_reg_b(input logic [7:0] v);
      @(negedge clk);
      reg_we_b = 1'b1; reg_wdata_b = v;
      @(negedge clk);
      reg_we_b = 1'b0;
   endtask

   // Wait for done on instance A; counts idle cycles seen while waiting.
   task automatic wait_done_a(input int limit, output bit seen, output int gap);
      seen = 1'b0; gap = 0;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (done_a) begin seen = 1'b1; break; end
         if (!busy_a) gap++;
      end
      #1;
   endtask

   task automatic wait_done_b(input int limit, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (done_b) begin seen = 1'b1; break; end
      end
      #1;
   endtask

   function automatic int oam_a_errs(input logic [15:0] base);
      int errs = 0;
      for (int i = 0; i < 160; i++) begin
         logic [15:0] ad;
         ad = base + 16'(i);
         if (oam_a[i] !== mem[ad]) errs++;
      end
      return errs;
   endfunction

   function automatic int oam_b_errs(input logic [15:0] base);
      int errs = 0;
      for (int i = 0; i < 160; i++) begin
         logic [15:0] ad;
         ad = base + 16'(i);
         if (oam_b[i] !== mem[ad]) errs++;
      end
      return errs;
   endfunction

   function automatic int hi_writes_a();
      int s = 0;
      for (int i = 80; i < 160; i++) s += wr_cnt_a[i];
      return s;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int  b0, d0, hw0, gap;
      bit  seen;
      logic [7:0] exp_rd;

      tests_run = 0; tests_failed = 0;
      reg_we_a = 1'b0; reg_wdata_a = '0;
      reg_we_b = 1'b0; reg_wdata_b = '0;
      for (int a = 0; a < 65536; a++) begin
         logic [15:0] ad;
         ad = 16'(a);
         mem[a] = (ad[7:0] * 8'd7) ^ ad[15:8] ^ 8'h5A;
      end

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      // Reset state
`ifdef OAM_DMA_READBACK_EN
      exp_rd = 8'h00;
`else
      exp_rd = 8'hFF;
`endif
      check_eq("rst_busy",     32'(busy_a),      32'd0);
      check_eq("rst_done",     32'(done_a),      32'd0);
      check_eq("rst_src_re",   32'(src_re_a),    32'd0);
      check_eq("rst_dst_we",   32'(dst_we_a),    32'd0);
      check_eq("rst_src_addr", 32'(src_addr_a),  32'h0000);
      check_eq("rst_dst_addr", 32'(dst_addr_a),  32'h00);
      check_eq("rst_rdata",    32'(reg_rdata_a), 32'(exp_rd));
      rst_n = 1'b1;

      // 1: page 0x80, full transfer
      b0 = busy_cyc_a; d0 = done_cnt_a;
      write_reg_a(8'h80);
      #1;
      check_eq("t1_busy_t1",   32'(busy_a),     32'd1);
      check_eq("t1_src_re_t1", 32'(src_re_a),   32'd1);
      check_eq("t1_src_addr",  32'(src_addr_a), 32'h8000);
      wait_done_a(2000, seen, gap);
      check_eq("t1_done_seen", 32'(seen),                 32'd1);
      check_eq("t1_done_busy", 32'(busy_a),               32'd0);
      check_eq("t1_busy_cyc",  32'(busy_cyc_a - b0),      32'd640);
      check_eq("t1_done_cnt",  32'(done_cnt_a - d0),      32'd1);
      check_eq("t1_oam",       32'(oam_a_errs(16'h8000)), 32'd0);
      $display("[TB] xfer page 0x80: busy=%0d done=%0d", busy_cyc_a - b0, done_cnt_a - d0);

      // 2: echo page 0xE1 folds to 0xC1
      write_reg_a(8'hE1);
      #1;
      check_eq("t2_src_addr0", 32'(src_addr_a), 32'hC100);
      wait_done_a(2000, seen, gap);
      check_eq("t2_done_seen", 32'(seen),                 32'd1);
      check_eq("t2_last_src",  32'(last_src_a),           32'hC19F);
      check_eq("t2_oam",       32'(oam_a_errs(16'hC100)), 32'd0);
      $display("[TB] xfer page 0xE1: last src 0x%04h", last_src_a);

      // 3: restart with 0xC0 around idx 50
      d0 = done_cnt_a;
      write_reg_a(8'h90);
      seen = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (src_re_a && src_addr_a[7:0] == 8'd50) begin seen = 1'b1; break; end
      end
      check_eq("t3_reach_idx50", 32'(seen), 32'd1);
      write_reg_a(8'hC0);
      #1;
      check_eq("t3_restart_addr", 32'(src_addr_a), 32'hC000);
      wait_done_a(2000, seen, gap);
      check_eq("t3_done_seen", 32'(seen),                 32'd1);
      check_eq("t3_busy_gap",  32'(gap),                  32'd0);
      check_eq("t3_done_cnt",  32'(done_cnt_a - d0),      32'd1);
      check_eq("t3_oam",       32'(oam_a_errs(16'hC000)), 32'd0);
      $display("[TB] xfer restart 0x90->0xC0: done=%0d gap=%0d", done_cnt_a - d0, gap);

      // 4: async reset at idx 80
      hw0 = hi_writes_a();
      write_reg_a(8'h85);
      seen = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (src_re_a && src_addr_a[7:0] == 8'd80) begin seen = 1'b1; break; end
      end
      check_eq("t4_reach_idx80", 32'(seen), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("t4_busy",   32'(busy_a),   32'd0);
      check_eq("t4_src_re", 32'(src_re_a), 32'd0);
      check_eq("t4_dst_we", 32'(dst_we_a), 32'd0);
      d0 = done_cnt_a;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check_eq("t4_no_done",   32'(done_cnt_a - d0),    32'd0);
      check_eq("t4_hi_writes", 32'(hi_writes_a() - hw0), 32'd0);
      $display("[TB] reset at idx 80: done=%0d hi_writes=%0d", done_cnt_a - d0, hi_writes_a() - hw0);

      // 5: instance B, 2 cycles per byte
      b0 = busy_cyc_b; d0 = done_cnt_b;
      write_reg_b(8'h81);
      wait_done_b(2000, seen);
      check_eq("t5_done_seen", 32'(seen),                 32'd1);
      check_eq("t5_busy_cyc",  32'(busy_cyc_b - b0),      32'd320);
      check_eq("t5_done_cnt",  32'(done_cnt_b - d0),      32'd1);
      check_eq("t5_alternate", 32'(alt_err_b),            32'd0);
      check_eq("t5_oam",       32'(oam_b_errs(16'h8100)), 32'd0);
      $display("[TB] xfer B page 0x81: busy=%0d", busy_cyc_b - b0);

      // 6: register readback
      write_reg_a(8'h9A);
      #1;
`ifdef OAM_DMA_READBACK_EN
      exp_rd = 8'h9A;
`else
      exp_rd = 8'hFF;
`endif
      check_eq("t6_readback", 32'(reg_rdata_a), 32'(exp_rd));
      wait_done_a(2000, seen, gap);
      check_eq("t6_done_seen", 32'(seen), 32'd1);
      $display("[TB] readback after 0x9A: 0x%02h", reg_rdata_a);

      // global invariants
      check_eq("no_overlap_a",   32'(overlap_a),   32'd0);
      check_eq("no_bad_addr_a",  32'(bad_addr_a),  32'd0);
      check_eq("no_bad_addr_b",  32'(bad_addr_b),  32'd0);
      check_eq("done_not_busy",  32'(done_busy_a), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
